// File: rtl/player_pkg.sv
// Shared constants for the player pipeline: playfield origin, tile size,
// collision bit indices, direction encodings and playerState field offsets.
package player_pkg;

  localparam int PLAYFIELD_X0 = 144;
  localparam int PLAYFIELD_Y0 = 35;
  localparam int TILE_SHIFT   = 5;

  localparam int COL_LEFT  = 0;
  localparam int COL_BOT   = 1;
  localparam int COL_RIGHT = 2;
  localparam int COL_TOP   = 3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  // playerState = {xPos[9:0], yPos[9:0], xSpeed[4:0], ySpeed[4:0], xDir, yDir}
  localparam int PS_XPOS_LSB = 22;
  localparam int PS_YPOS_LSB = 12;
  localparam int PS_XSPD_LSB = 7;
  localparam int PS_YSPD_LSB = 2;
  localparam int PS_XDIR     = 1;
  localparam int PS_YDIR     = 0;

  typedef logic signed [10:0] coord_t;

endpackage

// File: rtl/tile_index_calc.sv
// Pixel coordinate to tile-map address; anything left of / above the origin
// or beyond the map edge is flagged out-of-field and addresses tile 0.
module tile_index_calc
  import player_pkg::*;
#(
  parameter int MAP_COLS = 16,
  parameter int MAP_ROWS = 12
) (
  input  coord_t      px,
  input  coord_t      py,
  output logic        oob,
  output logic [7:0]  addr
);

  coord_t ox, oy, col, row;

  assign ox  = px - coord_t'(PLAYFIELD_X0);
  assign oy  = py - coord_t'(PLAYFIELD_Y0);
  assign col = ox >>> TILE_SHIFT;
  assign row = oy >>> TILE_SHIFT;

  assign oob = (ox < 0) || (oy < 0) ||
               (col >= coord_t'(MAP_COLS)) || (row >= coord_t'(MAP_ROWS));

  assign addr = oob ? 8'd0 : 8'(row[7:0] * 8'(MAP_COLS) + col[7:0]);

endmodule

// File: rtl/player_collision.sv
// Predicts the sprite's next position and probes its leading edges against the
// tile ROM. Define PLAYER_COL_CORNER_EN to add the diagonal-corner probe.
//
// state    | meaning
// ---------+------------------------------------------------
// IDLE     | waiting for step_req
// LATCH    | sample playerState, register predicted position
// ADDR     | drive tile_addr for probe[probe_idx]
// DATA     | fold ROM data (or out-of-field) into hit flags
// DONE     | col_valid high, playerCol holds new result
module player_collision
  import player_pkg::*;
#(
  parameter int MAP_COLS = 16,
  parameter int MAP_ROWS = 12,
  parameter int SPRITE_W = 32
) (
  input  logic        sim_clk,
  input  logic        reset_n,
  input  logic        step_req,
  input  logic [31:0] playerState,
  output logic [7:0]  tile_addr,
  input  logic        tile_solid,
  output logic [3:0]  playerCol,
  output logic        col_valid,
  output logic        busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

`ifdef PLAYER_COL_CORNER_EN
  localparam logic [2:0] LAST_PROBE = 3'd4;
`else
  localparam logic [2:0] LAST_PROBE = 3'd3;
`endif

  localparam coord_t SPAN = coord_t'(SPRITE_W - 1);

  logic [2:0] state;
  logic [2:0] probe_idx;
  coord_t     nx_r, ny_r;
  logic       x_dir_r, y_dir_r;
  logic       oob_r;
  logic       hit_h, hit_v, hit_c;

  logic [9:0] x_pos, y_pos;
  logic [4:0] x_spd, y_spd;
  logic       x_dir, y_dir;
  coord_t     vs_c, nx_c, ny_c;

  assign x_pos = playerState[PS_XPOS_LSB +: 10];
  assign y_pos = playerState[PS_YPOS_LSB +: 10];
  assign x_spd = playerState[PS_XSPD_LSB +: 5];
  assign y_spd = playerState[PS_YSPD_LSB +: 5];
  assign x_dir = playerState[PS_XDIR];
  assign y_dir = playerState[PS_YDIR];

  // Resting on the ground still needs a 1-pixel downward probe to see the floor.
  always_comb begin
    vs_c = coord_t'({6'b0, y_spd});
    if (y_dir == DIR_DOWN && y_spd == 5'd0) vs_c = 11'sd1;
    nx_c = (x_dir == DIR_RIGHT) ? coord_t'({1'b0, x_pos}) + coord_t'({6'b0, x_spd})
                                : coord_t'({1'b0, x_pos}) - coord_t'({6'b0, x_spd});
    ny_c = (y_dir == DIR_UP) ? coord_t'({1'b0, y_pos}) - vs_c
                             : coord_t'({1'b0, y_pos}) + vs_c;
  end

  coord_t lead_x, lead_y, probe_x, probe_y;
  logic   calc_oob;
  logic [7:0] calc_addr;

  assign lead_x = (x_dir_r == DIR_RIGHT) ? nx_r + SPAN : nx_r;
  assign lead_y = (y_dir_r == DIR_UP) ? ny_r : ny_r + SPAN;

  always_comb begin
    probe_x = lead_x;
    probe_y = lead_y;
    case (probe_idx)
      3'd0: begin probe_x = lead_x;      probe_y = ny_r;        end
      3'd1: begin probe_x = lead_x;      probe_y = ny_r + SPAN; end
      3'd2: begin probe_x = nx_r;        probe_y = lead_y;      end
      3'd3: begin probe_x = nx_r + SPAN; probe_y = lead_y;      end
      default: begin probe_x = lead_x;   probe_y = lead_y;      end
    endcase
  end

  tile_index_calc #(
    .MAP_COLS (MAP_COLS),
    .MAP_ROWS (MAP_ROWS)
  ) u_tile_index_calc (
    .px   (probe_x),
    .py   (probe_y),
    .oob  (calc_oob),
    .addr (calc_addr)
  );

  assign tile_addr = (state == ST_ADDR) ? calc_addr : 8'd0;
  assign busy      = (state != ST_IDLE);

  logic       solid;
  logic       hit_h_nx, hit_v_nx, hit_c_nx, v_final;
  logic [3:0] col_nx;

  assign solid = oob_r | tile_solid;

  always_comb begin
    hit_h_nx = hit_h;
    hit_v_nx = hit_v;
    hit_c_nx = hit_c;
    if (state == ST_DATA) begin
      case (probe_idx)
        3'd0, 3'd1: hit_h_nx = hit_h | solid;
        3'd2, 3'd3: hit_v_nx = hit_v | solid;
        default:    hit_c_nx = hit_c | solid;
      endcase
    end
`ifdef PLAYER_COL_CORNER_EN
    v_final = hit_v_nx | (hit_c_nx & ~hit_h_nx & ~hit_v_nx);
`else
    v_final = hit_v_nx;
`endif
    col_nx            = 4'b0000;
    col_nx[COL_LEFT]  = hit_h_nx & (x_dir_r == DIR_LEFT);
    col_nx[COL_RIGHT] = hit_h_nx & (x_dir_r == DIR_RIGHT);
    col_nx[COL_BOT]   = v_final & (y_dir_r == DIR_DOWN);
    col_nx[COL_TOP]   = v_final & (y_dir_r == DIR_UP);
  end

  always_ff @(posedge sim_clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      probe_idx <= 3'd0;
      nx_r      <= '0;
      ny_r      <= '0;
      x_dir_r   <= 1'b0;
      y_dir_r   <= 1'b0;
      oob_r     <= 1'b0;
      hit_h     <= 1'b0;
      hit_v     <= 1'b0;
      hit_c     <= 1'b0;
      playerCol <= 4'b0000;
      col_valid <= 1'b0;
    end else begin
      col_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (step_req) state <= ST_LATCH;
        end
        ST_LATCH: begin
          nx_r      <= nx_c;
          ny_r      <= ny_c;
          x_dir_r   <= x_dir;
          y_dir_r   <= y_dir;
          probe_idx <= 3'd0;
          hit_h     <= 1'b0;
          hit_v     <= 1'b0;
          hit_c     <= 1'b0;
          state     <= ST_ADDR;
        end
        ST_ADDR: begin
          oob_r <= calc_oob;
          state <= ST_DATA;
        end
        ST_DATA: begin
          hit_h <= hit_h_nx;
          hit_v <= hit_v_nx;
          hit_c <= hit_c_nx;
          if (probe_idx == LAST_PROBE) begin
            playerCol <= col_nx;
            col_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            probe_idx <= probe_idx + 3'd1;
            state     <= ST_ADDR;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_collision.sv
// Directed bench for player_collision with a behavioural 1-cycle tile ROM.
module tb_player_collision;

`ifdef PLAYER_COL_CORNER_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 10;
`endif

  logic        sim_clk = 1'b0;
  logic        reset_n;
  logic        step_req;
  logic [31:0] playerState;
  logic [7:0]  tile_addr;
  logic        tile_solid = 1'b0;
  logic [3:0]  playerCol;
  logic        col_valid;
  logic        busy;

  logic [255:0] map_bits;
  int n_vec = 0;
  int n_err = 0;

  always #5 sim_clk = ~sim_clk;

  always @(posedge sim_clk) tile_solid <= map_bits[tile_addr];

  player_collision dut (
    .sim_clk     (sim_clk),
    .reset_n     (reset_n),
    .step_req    (step_req),
    .playerState (playerState),
    .tile_addr   (tile_addr),
    .tile_solid  (tile_solid),
    .playerCol   (playerCol),
    .col_valid   (col_valid),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int x, input int y, input int xs, input int ys,
                                       input logic xd, input logic yd);
    return {10'(x), 10'(y), 5'(xs), 5'(ys), xd, yd};
  endfunction

  task automatic set_tile(input int row, input int col);
    map_bits[row*16 + col] = 1'b1;
  endtask

  // step_req is high in cycle 0; col_valid is expected in cycle LAT.
  task automatic run_step(input string tag, input logic [31:0] st, input logic [3:0] exp_col);
    int lat;
    int pulses;
    logic [3:0] col_seen;
    lat = -1;
    pulses = 0;
    col_seen = 4'b0000;
    @(negedge sim_clk);
    playerState = st;
    step_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge sim_clk);
      step_req = 1'b0;
      if (k == 1) check({tag, ".busy"}, 32'(busy), 32'd1);
      if (col_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          col_seen = playerCol;
        end
      end
    end
    check({tag, ".lat"}, 32'(lat), 32'(LAT));
    check({tag, ".pulses"}, 32'(pulses), 32'd1);
    check({tag, ".col"}, 32'(col_seen), 32'(exp_col));
    check({tag, ".hold"}, 32'(playerCol), 32'(exp_col));
  endtask

  initial begin
    int first;
    int pulses;
    reset_n     = 1'b0;
    step_req    = 1'b0;
    playerState = '0;
    map_bits    = '0;
    repeat (3) @(negedge sim_clk);
    check("rst.col", 32'(playerCol), 32'd0);
    check("rst.valid", 32'(col_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.addr", 32'(tile_addr), 32'd0);
    reset_n = 1'b1;

    // Floor under the left half of the sprite only.
    map_bits = '0;
    set_tile(3, 1);
    run_step("floor", pack(176, 99, 4, 0, 1'b1, 1'b0), 4'b0010);

    map_bits = '0;
    set_tile(3, 15);
    run_step("wall", pack(592, 110, 4, 0, 1'b1, 1'b1), 4'b0100);

    map_bits = '0;
    run_step("oob_left", pack(146, 99, 4, 0, 1'b0, 1'b1), 4'b1001);

    map_bits = '0;
    set_tile(1, 5);
    run_step("ceiling", pack(300, 99, 2, 5, 1'b0, 1'b1), 4'b1000);

    map_bits = '0;
    run_step("free", pack(300, 200, 3, 2, 1'b1, 1'b0), 4'b0000);

    map_bits = '0;
    run_step("oob_bottom", pack(300, 500, 0, 3, 1'b1, 1'b0), 4'b0110);

    map_bits = '0;
    set_tile(2, 3);
    run_step("zero_speed", pack(250, 110, 0, 0, 1'b0, 1'b0), 4'b0001);

    // Second request in cycle 4 lands while busy and must be dropped.
    map_bits = '0;
    first = -1;
    pulses = 0;
    @(negedge sim_clk);
    playerState = pack(300, 200, 3, 2, 1'b1, 1'b0);
    step_req = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge sim_clk);
      step_req = (k == 4);
      if (col_valid) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    check("overlap.pulses", 32'(pulses), 32'd1);
    check("overlap.lat", 32'(first), 32'(LAT));

    // Reset in cycle 5 aborts the evaluation.
    map_bits = '0;
    set_tile(3, 1);
    pulses = 0;
    @(negedge sim_clk);
    playerState = pack(176, 99, 4, 0, 1'b1, 1'b0);
    step_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge sim_clk);
      step_req = 1'b0;
      reset_n = (k != 5);
      if (k == 6) begin
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.col", 32'(playerCol), 32'd0);
      end
      if (col_valid) pulses++;
    end
    reset_n = 1'b1;
    check("abort.pulses", 32'(pulses), 32'd0);
    run_step("after_abort", pack(176, 99, 4, 0, 1'b1, 1'b0), 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
